sram_bus_arbiter: RTL

Three-master arbiter placed between the core's memory ports and the single-port `sirv_sim_ram` inside `srambus`. It grants exactly one of the following masters per cycle and routes its command to the RAM:
- debug/loader (M0)
- load/store unit (M1)
- instruction fetch (M2)

It returns read data one cycle later to the master that issued the read. It provides a bus lock for M1 read-modify-write sequences and a starvation guard so instruction fetch always makes progress.

---
 rtl/sram_arb_pkg.sv | 26 ++
 rtl/sram_arb_prio.sv | 28 ++
 rtl/sram_bus_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared constants for the SRAM bus arbiter: master indices, FSM encoding,
// default starvation limit and a one-hot to index helper.
package sram_arb_pkg;

  // Master indices into the req/gnt vectors
  localparam logic [1:0] MST_DBG = 2'd0;
  localparam logic [1:0] MST_LSU = 2'd1;
  localparam logic [1:0] MST_IFU = 2'd2;

  // Arbiter FSM encoding
  localparam logic [0:0] ARB_IDLE   = 1'b0;
  localparam logic [0:0] ARB_LOCKED = 1'b1;

  // Consecutive denied fetch cycles before instruction fetch is forced to win
  localparam int DEFAULT_STARVE_LIMIT = 4;

  // Converts a one-hot grant vector to a master index (0 when empty)
  function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
    logic [1:0] idx;
    idx = MST_DBG;
    if (oh[MST_LSU]) idx = MST_LSU;
    if (oh[MST_IFU]) idx = MST_IFU;
    return idx;
  endfunction

endpackage

// File: rtl/sram_arb_prio.sv
// Combinational priority picker. Produces a one-hot grant from the request
// vector, honouring the M1 bus lock and the fetch starvation override.
module sram_arb_prio
  import sram_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic       locked,
  input  logic       starve_hit,
  output logic [2:0] gnt
);

  // Lock beats starvation override, which beats the fixed M0 > M1 > M2 order
  always_comb begin
    gnt = 3'b000;
    if (locked) begin
      gnt[MST_LSU] = req[MST_LSU];
    end else if (starve_hit && req[MST_IFU]) begin
      gnt[MST_IFU] = 1'b1;
    end else if (req[MST_DBG]) begin
      gnt[MST_DBG] = 1'b1;
    end else if (req[MST_LSU]) begin
      gnt[MST_LSU] = 1'b1;
    end else if (req[MST_IFU]) begin
      gnt[MST_IFU] = 1'b1;
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Three-master arbiter in front of a single-port SRAM. Grants one master per
// cycle, muxes its command to the RAM and routes read data back one cycle
// later to the master that issued the read. Supports an M1 bus lock for
// read-modify-write and a starvation guard for instruction fetch.
//
// Handshake: a master raises mX_req with its command fields and holds them
// until mX_gnt. mX_gnt is combinational in the same cycle; the command is
// transferred on the rising edge where req & gnt are both high. A granted
// read returns mX_rvalid for exactly one cycle, one cycle after the grant.
module sram_bus_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m0_req,
  input  logic                    m0_we,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
  input  logic                    m1_req,
  input  logic                    m1_we,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
  input  logic                    m1_lock,
  input  logic                    m2_req,
  input  logic                    m2_we,
  input  logic [ADDR_WIDTH-1:0]   m2_addr,
  input  logic [DATA_WIDTH-1:0]   m2_wdata,
  input  logic [DATA_WIDTH/8-1:0] m2_wstrb,
  output logic                    m0_gnt,
  output logic                    m1_gnt,
  output logic                    m2_gnt,
  output logic                    m0_rvalid,
  output logic                    m1_rvalid,
  output logic                    m2_rvalid,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic [DATA_WIDTH-1:0]   m2_rdata,
  output logic                    ram_cs,
  output logic                    ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  output logic [DATA_WIDTH/8-1:0] ram_wem,
  input  logic [DATA_WIDTH-1:0]   ram_rdata,
  output logic [0:0]              dbg_state,
  output logic [3:0]              dbg_starve_cnt
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [0:0] state_q;
  logic [0:0] state_d;
  logic [3:0] starve_cnt_q;
  logic       starve_hit;
  logic [2:0] req;
  logic [2:0] gnt;
  logic [1:0] win_idx;
  logic       rd_grant;
  logic       rd_pend_q;
  logic [1:0] rd_owner_q;

  assign req        = {m2_req, m1_req, m0_req};
  assign starve_hit = (starve_cnt_q == LIMIT);

  sram_arb_prio u_prio (
    .req        (req),
    .locked     (state_q == ARB_LOCKED),
    .starve_hit (starve_hit),
    .gnt        (gnt)
  );

  assign m0_gnt  = gnt[MST_DBG];
  assign m1_gnt  = gnt[MST_LSU];
  assign m2_gnt  = gnt[MST_IFU];
  assign win_idx = onehot_to_idx(gnt);

  // RAM command mux: winner's fields, all zero when nothing is granted
  always_comb begin
    ram_cs    = |gnt;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wem   = '0;
    case (gnt)
      3'b001: begin
        ram_we    = m0_we;
        ram_addr  = m0_addr;
        ram_wdata = m0_wdata;
        ram_wem   = m0_wstrb;
      end
      3'b010: begin
        ram_we    = m1_we;
        ram_addr  = m1_addr;
        ram_wdata = m1_wdata;
        ram_wem   = m1_wstrb;
      end
      3'b100: begin
        ram_we    = m2_we;
        ram_addr  = m2_addr;
        ram_wdata = m2_wdata;
        ram_wem   = m2_wstrb;
      end
      default: ;
    endcase
  end

  // Lock FSM next state: enter on a locked M1 grant, leave once M1 drops lock
  always_comb begin
    state_d = state_q;
    if (state_q == ARB_IDLE) begin
      if (gnt[MST_LSU] && m1_lock) state_d = ARB_LOCKED;
    end else begin
      if ((gnt[MST_LSU] && !m1_lock) || (!m1_req && !m1_lock)) state_d = ARB_IDLE;
    end
  end

  // Lock FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ARB_IDLE;
    else     state_q <= state_d;
  end

  // Fetch starvation counter: counts denied M2 cycles, saturates at the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= 4'd0;
    end else if (!m2_req || m2_gnt) begin
      starve_cnt_q <= 4'd0;
    end else if (!starve_hit) begin
      starve_cnt_q <= starve_cnt_q + 4'd1;
    end
  end

  assign rd_grant = ram_cs && !ram_we;

  // Read-return tracking: remembers who issued the read granted this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= MST_DBG;
    end else begin
      rd_pend_q <= rd_grant;
      if (rd_grant) rd_owner_q <= win_idx;
    end
  end

  assign m0_rvalid = rd_pend_q && (rd_owner_q == MST_DBG);
  assign m1_rvalid = rd_pend_q && (rd_owner_q == MST_LSU);
  assign m2_rvalid = rd_pend_q && (rd_owner_q == MST_IFU);
  assign m0_rdata  = ram_rdata;
  assign m1_rdata  = ram_rdata;
  assign m2_rdata  = ram_rdata;

  assign dbg_state      = state_q;
  assign dbg_starve_cnt = starve_cnt_q;

endmodule
